regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-read-port, single-write-port register file. Successor to the fixed 32x32 two-read register file used by the datapath decode stage.
- Adds configurable width, depth and read-port count, an optional hardwired zero register, and a sequential clear engine. Clearing happens one entry per cycle, so large depths do not need a single-cycle wide reset.
- Sits between the decode stage (read addresses) and the writeback stage (write port).

Parameters:
- DATA_W, 32, data width of each entry.
- ADDR_W, 5, address width.
- DEPTH, 32, number of implemented entries (1 to 2**ADDR_W).
- NUM_RD, 2, number of independent read ports (1 to 8).
- ZERO_REG, 1, if 1 then entry 0 always reads 0 and writes to it are dropped.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- clr  in  1  synchronous, active-high reset; starts a full clear.
- clear_req  in  1  soft clear request; single-cycle pulse, honoured only in IDLE.
- wr_en  in  1  write enable.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k at [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data; port k at [k*DATA_W +: DATA_W].
- busy  out  1  high while clearing.
- wr_err  out  1  registered one-cycle pulse flagging a dropped write.

Behaviour:
- Interface: one clock `clk`; reset `clr` is synchronous and active-high.
- **State machine** (2 states, IDLE and CLEAR):
  - Clear pointer `clr_ptr` is $clog2(DEPTH) bits wide.
  - clr=1 at an edge forces state=CLEAR, clr_ptr=0 and wr_err=0; this overrides everything else.
  - In CLEAR, each edge writes 0 to mem[clr_ptr] and increments clr_ptr.
  - When clr_ptr==DEPTH-1, that entry is written and state goes to IDLE; busy=0 from the next cycle.
  - A full clear takes exactly DEPTH cycles after clr deasserts. While clr is held, clr_ptr stays at 0.
  - In IDLE, clear_req=1 moves to CLEAR with clr_ptr=0 at the next edge. clear_req is ignored in CLEAR.
- **Outputs:**
  - busy = (state==CLEAR), combinational from state. It is 1 in the cycle after any clr edge.
  - rd_data is all zeros whenever busy=1.
  - wr_err resets to 0.
- **Write** (IDLE only): committed at the rising edge when all of the following hold:
  - wr_en=1;
  - wr_addr<DEPTH;
  - not (ZERO_REG && wr_addr==0).
- **Dropped writes:**
  - wr_en=1 while busy, or with wr_addr>=DEPTH: the write is dropped and wr_err=1 in the following cycle.
  - A write to reg 0 with ZERO_REG=1 is dropped silently, without wr_err.
  - A clear_req edge in IDLE with wr_en=1 also drops the write and flags wr_err.
- **Read:** combinational, asynchronous, zero latency, no read-enable gating.
  - rd_data[k] = mem[rd_addr[k]].
  - Returns 0 when rd_addr[k]>=DEPTH, or when ZERO_REG and rd_addr[k]==0.
  - All ports may read the same address simultaneously.
- **Read-during-write, same address:** without the bypass feature, the read returns the old value until the edge.
- Unimplemented addresses never alias onto implemented entries; no wrap-around.
- A clr asserted mid-clear restarts the clear from entry 0.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding on every port. rd_data[k] = wr_data in the same cycle when all of the following hold:
  - a write would commit this cycle (per the write rules above);
  - rd_addr[k]==wr_addr.
- Otherwise identical behaviour; the zero-register and busy rules take priority over forwarding.
- Not defined: no forwarding path. Reads show the pre-write value in the write cycle and the new value from the next cycle.

Decomposition:
- Package regfile_pkg holds:
  - typedef enum logic {IDLE, CLEAR} rf_state_t;
  - localparam defaults RF_DATA_W=32, RF_ADDR_W=5, RF_NUM_RD=2.
- One sub-module, regfile_clear_fsm:
  - Contains the state register, clr_ptr and busy.
  - Outputs clr_we and clr_addr to the array.
- The top level holds the storage array, write qualification, wr_err, and a per-port read mux generated with a for-generate over NUM_RD.

Test Plan:
- Reset clear: DEPTH=32, pulse clr 1 cycle → busy=1 for exactly 32 cycles then 0; all ports read 0; wr_err=0.
- Write/read: write 0xDEADBEEF to reg 5, read port0=5 and port1=5 next cycle → both 0xDEADBEEF. Write 0x1234 to reg 0 → reads 0 and no wr_err.
- Dropped writes:
  - wr_en to reg 3 while busy → wr_err=1 one cycle later, reg 3 reads 0 after clear.
  - DEPTH=20, write addr 25 → wr_err=1, and reads of addr 25 and addr 9 return 0.
- Soft clear mid-traffic: fill regs 1..31 with their index, pulse clear_req → busy 32 cycles, all reads 0. Second clear_req during busy → no restart, so busy still ends at cycle 32.
- clr mid-clear: assert clr at clear cycle 10 → busy stays high 32 further cycles after clr deasserts.
- Bypass, NUM_RD=4, write 0xA5A5A5A5 to reg 7 with all ports reading 7 in the same cycle:
  - REGFILE_BYPASS_EN defined: 0xA5A5A5A5 on all ports that cycle.
  - Not defined: old value that cycle, 0xA5A5A5A5 on the next.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
// No timing or flow control of its own; imported by regfile_clear_fsm and regfile_mp.
package regfile_pkg;
    typedef enum logic {IDLE, CLEAR} rf_state_t;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_NUM_RD = 2;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/regfile_clear_fsm.sv
// Sequential clear engine: zeroes one entry per cycle, DEPTH cycles per clear.
// clear_req is ignored while busy; a clr restarts the sweep from entry 0.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int PTR_W = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             clear_req,
    output logic             busy,
    output logic             clr_we,
    output logic [PTR_W-1:0] clr_addr
);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    rf_state_t        state, state_nxt;
    logic [PTR_W-1:0] clr_ptr, ptr_nxt;

    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = clr_ptr;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_nxt = CLEAR;
                    ptr_nxt   = '0;
                end
            end
            CLEAR: begin
                if (clr_ptr == LAST) begin
                    state_nxt = IDLE;
                    ptr_nxt   = '0;
                end else begin
                    ptr_nxt = clr_ptr + PTR_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy     = (state == CLEAR);
    assign clr_we   = busy;
    assign clr_addr = clr_ptr;
endmodule

// File: rtl/regfile_mp.sv
// Multi-read/single-write register file; zero-latency reads, writes commit at the edge.
// Writes during clear or out of range are dropped and flagged on wr_err; REGFILE_BYPASS_EN adds write-to-read forwarding.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = RF_NUM_RD,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     clear_req,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic                     busy,
    output logic                     wr_err
);
    localparam int              PTR_W   = ptr_w(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              clr_we;
    logic [PTR_W-1:0]  clr_addr;
    logic              wr_in_range, wr_hit_zero, wr_commit, wr_drop;

    regfile_clear_fsm #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_clear_fsm (
        .clk       (clk),
        .clr       (clr),
        .clear_req (clear_req),
        .busy      (busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_A);
    assign wr_hit_zero = (ZERO_REG != 0) && (wr_addr == '0);
    // A clear_req accepted this edge takes priority over a coincident write.
    assign wr_commit   = wr_en && !clr && !busy && !clear_req && wr_in_range && !wr_hit_zero;
    assign wr_drop     = wr_en && (busy || clear_req || !wr_in_range);

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_drop;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_commit) begin
            mem[wr_addr[PTR_W-1:0]] <= wr_data;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              ra_ok;
        logic [DATA_W-1:0] rv;

        assign ra    = rd_addr[k*ADDR_W +: ADDR_W];
        assign ra_ok = ({1'b0, ra} < DEPTH_A) && !((ZERO_REG != 0) && (ra == '0));

        always_comb begin
            rv = '0;
            if (!busy && ra_ok) begin
                rv = mem[ra[PTR_W-1:0]];
`ifdef REGFILE_BYPASS_EN
                if (wr_commit && (ra == wr_addr)) begin
                    rv = wr_data;
                end
`endif
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = rv;
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a 32-entry 4-port instance and a 20-entry 2-port instance.
module tb_regfile_mp;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         clr_a, creq_a, wen_a, busy_a, werr_a;
    logic [4:0]   waddr_a;
    logic [31:0]  wdata_a;
    logic [19:0]  raddr_a;
    logic [127:0] rdata_a;

    logic         clr_b, creq_b, wen_b, busy_b, werr_b;
    logic [4:0]   waddr_b;
    logic [31:0]  wdata_b;
    logic [9:0]   raddr_b;
    logic [63:0]  rdata_b;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .NUM_RD(4), .ZERO_REG(1)) dut_a (
        .clk(clk), .clr(clr_a), .clear_req(creq_a), .wr_en(wen_a), .wr_addr(waddr_a),
        .wr_data(wdata_a), .rd_addr(raddr_a), .rd_data(rdata_a), .busy(busy_a), .wr_err(werr_a)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .DEPTH(20), .NUM_RD(2), .ZERO_REG(1)) dut_b (
        .clk(clk), .clr(clr_b), .clear_req(creq_b), .wr_en(wen_b), .wr_addr(waddr_b),
        .wr_data(wdata_b), .rd_addr(raddr_b), .rd_data(rdata_b), .busy(busy_b), .wr_err(werr_b)
    );

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rda(input int k);
        return rdata_a[k*32 +: 32];
    endfunction

    function automatic logic [31:0] rdb(input int k);
        return rdata_b[k*32 +: 32];
    endfunction

    task automatic rd_all_a(input logic [4:0] a);
        raddr_a = {4{a}};
    endtask

    task automatic count_busy_a(input string tag);
        int cnt;
        cnt = 0;
        while (busy_a && cnt < 100) begin
            cnt++;
            tick();
        end
        exp_q.push_back(32'd32);
        chk(tag, cnt);
    endtask

    initial begin
        int ca, cb, guard;
        clr_a = 1'b1; creq_a = 1'b0; wen_a = 1'b0; waddr_a = '0; wdata_a = '0; raddr_a = '0;
        clr_b = 1'b1; creq_b = 1'b0; wen_b = 1'b0; waddr_b = '0; wdata_b = '0; raddr_b = '0;

        // Reset clear: clr held two edges, then both sweeps run
        tick();
        tick();
        exp_q.push_back(32'd1); chk("busy_in_clr", busy_a);
        clr_a = 1'b0; clr_b = 1'b0;
        rd_all_a(5'd5);
        #1;
        exp_q.push_back(32'd0); chk("werr_after_clr", werr_a);
        exp_q.push_back(32'd0); chk("rd_zero_busy", rda(2));
        ca = 0; cb = 0; guard = 0;
        while ((busy_a || busy_b) && guard < 100) begin
            if (busy_a) ca++;
            if (busy_b) cb++;
            guard++;
            tick();
        end
        exp_q.push_back(32'd32); chk("busy_len_a", ca);
        exp_q.push_back(32'd20); chk("busy_len_b", cb);
        for (int i = 0; i < 32; i++) begin
            rd_all_a(i[4:0]);
            #1;
            exp_q.push_back(32'd0); chk("post_clr_rd", rda(i % 4));
        end

        // Single write, dual-port readback
        wen_a = 1'b1; waddr_a = 5'd5; wdata_a = 32'hDEADBEEF; rd_all_a(5'd5);
        #1;
        exp_q.push_back(BYP ? 32'hDEADBEEF : 32'h0); chk("rdw_same_cycle", rda(0));
        tick();
        wen_a = 1'b0;
        #1;
        exp_q.push_back(32'hDEADBEEF); chk("rd5_p0", rda(0));
        exp_q.push_back(32'hDEADBEEF); chk("rd5_p1", rda(1));
        exp_q.push_back(32'd0); chk("werr_good_wr", werr_a);

        // Zero register: write dropped silently, forwarding suppressed
        wen_a = 1'b1; waddr_a = 5'd0; wdata_a = 32'h1234; rd_all_a(5'd0);
        #1;
        exp_q.push_back(32'd0); chk("rd0_same_cycle", rda(3));
        tick();
        wen_a = 1'b0;
        #1;
        exp_q.push_back(32'd0); chk("rd0_after", rda(0));
        exp_q.push_back(32'd0); chk("werr_reg0", werr_a);

        // Fill 1..31 with their index and read them all back
        for (int i = 1; i < 32; i++) begin
            wen_a = 1'b1; waddr_a = i[4:0]; wdata_a = i;
            tick();
        end
        wen_a = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rd_all_a(i[4:0]);
            #1;
            exp_q.push_back((i == 0) ? 32'd0 : 32'(i)); chk("fill_rd", rda(i % 4));
        end

        // Soft clear with coincident write, then write and clear_req while busy
        creq_a = 1'b1; wen_a = 1'b1; waddr_a = 5'd3; wdata_a = 32'hFF;
        tick();
        rd_all_a(5'd3);
        #1;
        exp_q.push_back(32'd1); chk("busy_soft", busy_a);
        exp_q.push_back(32'd1); chk("werr_creq_wr", werr_a);
        exp_q.push_back(32'd0); chk("rd_busy_soft", rda(1));
        creq_a = 1'b1; wen_a = 1'b1; waddr_a = 5'd3; wdata_a = 32'h77;
        tick();
        creq_a = 1'b0; wen_a = 1'b0;
        exp_q.push_back(32'd1); chk("werr_wr_busy", werr_a);
        begin
            int cnt;
            cnt = 1;
            while (busy_a && cnt < 100) begin
                cnt++;
                tick();
            end
            exp_q.push_back(32'd32); chk("busy_len_soft", cnt);
        end
        exp_q.push_back(32'd0); chk("werr_idle", werr_a);
        for (int i = 0; i < 32; i++) begin
            rd_all_a(i[4:0]);
            #1;
            exp_q.push_back(32'd0); chk("soft_clr_rd", rda(i % 4));
        end
        rd_all_a(5'd3);
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(32'd0); chk("reg3_dropped", rda(k));
        end

        // clr in the middle of a soft clear restarts the sweep
        wen_a = 1'b1; waddr_a = 5'd9; wdata_a = 32'h99;
        tick();
        wen_a = 1'b0; creq_a = 1'b1;
        tick();
        creq_a = 1'b0;
        repeat (10) tick();
        exp_q.push_back(32'd1); chk("busy_mid_clear", busy_a);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        count_busy_a("busy_len_restart");
        rd_all_a(5'd9);
        #1;
        exp_q.push_back(32'd0); chk("reg9_cleared", rda(0));

        // Read-during-write on all four ports
        wen_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'h11111111;
        tick();
        wen_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'hA5A5A5A5; rd_all_a(5'd7);
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(BYP ? 32'hA5A5A5A5 : 32'h11111111); chk("byp_same_cycle", rda(k));
        end
        tick();
        wen_a = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(32'hA5A5A5A5); chk("byp_next_cycle", rda(k));
        end

        // Out-of-range writes on the 20-entry instance
        wen_b = 1'b1; waddr_b = 5'd25; wdata_b = 32'hCAFE;
        tick();
        wen_b = 1'b0; raddr_b = {5'd9, 5'd25};
        #1;
        exp_q.push_back(32'd1); chk("werr_oor", werr_b);
        exp_q.push_back(32'd0); chk("rd_oor_25", rdb(0));
        exp_q.push_back(32'd0); chk("rd_alias_9", rdb(1));
        tick();
        exp_q.push_back(32'd0); chk("werr_oor_pulse", werr_b);
        wen_b = 1'b1; waddr_b = 5'd19; wdata_b = 32'h19;
        tick();
        wen_b = 1'b1; waddr_b = 5'd20; wdata_b = 32'hBAD;
        raddr_b = {5'd19, 5'd19};
        #1;
        exp_q.push_back(32'h19); chk("rd_last_entry", rdb(0));
        exp_q.push_back(32'd0); chk("werr_last_entry", werr_b);
        tick();
        wen_b = 1'b0; raddr_b = {5'd4, 5'd20};
        #1;
        exp_q.push_back(32'd1); chk("werr_addr20", werr_b);
        exp_q.push_back(32'd0); chk("rd_addr20", rdb(0));
        exp_q.push_back(32'd0); chk("rd_alias_4", rdb(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
